// File: rtl/video_pkg.sv
// Shared video definitions: pattern encoding, pixel width, default raster timing.
package video_pkg;

    localparam int unsigned DATA_W = 10;

    localparam int unsigned DEF_HSW  = 1;
    localparam int unsigned DEF_HBP  = 2;
    localparam int unsigned DEF_HACT = 10;
    localparam int unsigned DEF_HFP  = 2;
    localparam int unsigned DEF_VSW  = 1;
    localparam int unsigned DEF_VBP  = 1;
    localparam int unsigned DEF_VACT = 4;
    localparam int unsigned DEF_VFP  = 1;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_ID    = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vt_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
    } rgb_t;

    // Timing decode for one counter position, before pattern generation.
    typedef struct packed {
        logic              vsync;
        logic              hsync;
        logic              de;
        logic              frame_start;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } timing_t;

    // Counter width able to hold 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern colour for one pixel position; purely combinational.
module video_pattern_gen
    import video_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    input  logic [DATA_W-1:0] i_frame,
    input  pattern_e          i_pattern,
    output rgb_t              o_rgb_c
);

    logic [DATA_W-1:0] check_c;

    always_comb begin
        check_c = (i_x[0] ^ i_y[0]) ? '1 : '0;
        o_rgb_c = '0;
        case (i_pattern)
            PAT_HRAMP: o_rgb_c = '{r: i_x, g: i_x, b: i_x};
            PAT_VRAMP: o_rgb_c = '{r: i_y, g: i_y, b: i_y};
            PAT_CHECK: o_rgb_c = '{r: check_c, g: check_c, b: check_c};
            PAT_ID:    o_rgb_c = '{r: i_x, g: i_y, b: i_frame};
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with test patterns: counters, run/idle control,
// two register stages (timing decode, then RGB) to the outputs.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned HSW  = DEF_HSW,
    parameter int unsigned HBP  = DEF_HBP,
    parameter int unsigned HACT = DEF_HACT,
    parameter int unsigned HFP  = DEF_HFP,
    parameter int unsigned VSW  = DEF_VSW,
    parameter int unsigned VBP  = DEF_VBP,
    parameter int unsigned VACT = DEF_VACT,
    parameter int unsigned VFP  = DEF_VFP
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic [1:0]        i_pattern,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_de,
    output logic [DATA_W-1:0] o_r_data,
    output logic [DATA_W-1:0] o_g_data,
    output logic [DATA_W-1:0] o_b_data,
    output logic              o_frame_start
);

    localparam int unsigned HTOT = HSW + HBP + HACT + HFP;
    localparam int unsigned VTOT = VSW + VBP + VACT + VFP;
    localparam int unsigned H_W  = cnt_w(HTOT);
    localparam int unsigned V_W  = cnt_w(VTOT);
    localparam int unsigned HA0  = HSW + HBP;
    localparam int unsigned HA1  = HA0 + HACT;
    localparam int unsigned VA0  = VSW + VBP;
    localparam int unsigned VA1  = VA0 + VACT;

    vt_state_e         state_q, state_d;
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
    pattern_e          pattern_q, pattern_d;
    timing_t           tim_q, tim_d;
    logic              vsync_q, vsync_d;
    logic              hsync_q, hsync_d;
    logic              de_q, de_d;
    logic              fs_q, fs_d;
    rgb_t              rgb_q, rgb_d;
    rgb_t              pat_rgb_c;
    logic              h_last_c, v_last_c, origin_c;

    video_pattern_gen u_pattern (
        .i_x       (tim_q.x),
        .i_y       (tim_q.y),
        .i_frame   (frame_cnt_q),
        .i_pattern (pattern_q),
        .o_rgb_c   (pat_rgb_c)
    );

    // Next state, counters, and both output pipeline stages.
    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pattern_d   = pattern_q;
        tim_d       = '0;

        h_last_c = (h_cnt_q == H_W'(HTOT - 1));
        v_last_c = (v_cnt_q == V_W'(VTOT - 1));
        origin_c = (h_cnt_q == '0) && (v_cnt_q == '0);

        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (i_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (origin_c) begin
                    pattern_d = pattern_e'(i_pattern);
                end
                if (h_last_c) begin
                    h_cnt_d = '0;
                    v_cnt_d = v_last_c ? '0 : v_cnt_q + V_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + H_W'(1);
                end
                // Stopping is only allowed once the whole frame has been sent.
                if (h_last_c && v_last_c) begin
                    frame_cnt_d = frame_cnt_q + DATA_W'(1);
                    if (!i_en) begin
                        state_d = ST_IDLE;
                    end
                end
                tim_d.hsync       = (h_cnt_q < H_W'(HSW));
                tim_d.vsync       = (v_cnt_q < V_W'(VSW));
                tim_d.de          = (h_cnt_q >= H_W'(HA0)) && (h_cnt_q < H_W'(HA1)) &&
                                    (v_cnt_q >= V_W'(VA0)) && (v_cnt_q < V_W'(VA1));
                tim_d.frame_start = origin_c;
                tim_d.x           = DATA_W'(h_cnt_q - H_W'(HA0));
                tim_d.y           = DATA_W'(v_cnt_q - V_W'(VA0));
            end
        endcase

        vsync_d = tim_q.vsync;
        hsync_d = tim_q.hsync;
        de_d    = tim_q.de;
        fs_d    = tim_q.frame_start;
        rgb_d   = tim_q.de ? pat_rgb_c : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            pattern_q   <= PAT_HRAMP;
            tim_q       <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pattern_q   <= pattern_d;
            tim_q       <= tim_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign o_vsync       = vsync_q;
    assign o_hsync       = hsync_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_r_data      = rgb_q.r;
    assign o_g_data      = rgb_q.g;
    assign o_b_data      = rgb_q.b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: per-cycle reference model, phase table, corner sequences.
module tb_video_timing_gen;

    localparam int HSW = 1, HBP = 2, HACT = 10, HFP = 2;
    localparam int VSW = 1, VBP = 1, VACT = 4, VFP = 1;
    localparam int HTOT = HSW + HBP + HACT + HFP;
    localparam int VTOT = VSW + VBP + VACT + VFP;
    localparam int FTOT = HTOT * VTOT;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_en = 1'b0;
    logic [1:0] i_pattern = 2'd0;
    logic       o_vsync, o_hsync, o_de, o_frame_start;
    logic [9:0] o_r_data, o_g_data, o_b_data;

    video_timing_gen dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_en          (i_en),
        .i_pattern     (i_pattern),
        .o_vsync       (o_vsync),
        .o_hsync       (o_hsync),
        .o_de          (o_de),
        .o_r_data      (o_r_data),
        .o_g_data      (o_g_data),
        .o_b_data      (o_b_data),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: position within the frame, in cycles, plus one-edge output lag.
    bit          m_run;
    int          m_t, m_frame, m_pat;
    logic [33:0] m_pend, m_exp;

    int cnt_de, cnt_fs, cnt_hs, cnt_vs;
    logic [9:0] pix_r[40], pix_g[40], pix_b[40];
    int pix_idx;

    typedef struct {
        logic       en;
        logic [1:0] pat;
        int         edges;
        int         de;
        int         fs;
        int         hs;
        int         vs;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [33:0] pixel(input int t, input int pat, input int fr);
        int h, v, x, y;
        logic hs, vs, de, fs;
        logic [9:0] r, g, b;
        h  = t % HTOT;
        v  = t / HTOT;
        hs = (h < HSW);
        vs = (v < VSW);
        de = (h >= HSW + HBP) && (h < HSW + HBP + HACT) && (v >= VSW + VBP) && (v < VSW + VBP + VACT);
        fs = (t == 0);
        x  = h - (HSW + HBP);
        y  = v - (VSW + VBP);
        r = '0; g = '0; b = '0;
        if (de) begin
            case (pat)
                0: begin r = 10'(x); g = 10'(x); b = 10'(x); end
                1: begin r = 10'(y); g = 10'(y); b = 10'(y); end
                2: begin r = ((x ^ y) & 1) != 0 ? 10'h3FF : 10'h000; g = r; b = r; end
                default: begin r = 10'(x); g = 10'(y); b = 10'(fr); end
            endcase
        end
        return {vs, hs, de, fs, r, g, b};
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_frame = 0; m_pat = 0;
        m_pend = '0; m_exp = '0;
    endtask

    task automatic model_edge();
        logic [33:0] cur;
        if (!rstn) begin
            model_reset();
            return;
        end
        cur = '0;
        if (m_run) begin
            if (m_t == 0) m_pat = int'(i_pattern);
            cur = pixel(m_t, m_pat, m_frame);
        end
        m_exp  = m_pend;
        m_pend = cur;
        if (m_run) begin
            if (m_t == FTOT - 1) begin
                m_t     = 0;
                m_frame = (m_frame + 1) % 1024;
                m_run   = i_en;
            end else begin
                m_t++;
            end
        end else if (i_en) begin
            m_run = 1;
            m_t   = 0;
        end
    endtask

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [33:0] dut_vec();
        return {o_vsync, o_hsync, o_de, o_frame_start, o_r_data, o_g_data, o_b_data};
    endfunction

    task automatic clear_counts();
        cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
    endtask

    // One clock: advance model, sample DUT 1ns after the edge, compare, collect stats.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", dut_vec(), m_exp);
        cnt_de += int'(o_de);
        cnt_fs += int'(o_frame_start);
        cnt_hs += int'(o_hsync);
        cnt_vs += int'(o_vsync);
        if (o_frame_start) pix_idx = 0;
        if (o_de && pix_idx < 40) begin
            pix_r[pix_idx] = o_r_data;
            pix_g[pix_idx] = o_g_data;
            pix_b[pix_idx] = o_b_data;
            pix_idx++;
        end
    endtask

    task automatic run_until_fs(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = o_frame_start;
        end
        check("fs_seen", 34'(seen), 34'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_en = 1'b0;
        i_pattern = 2'd0;
        model_reset();
        repeat (2) step();
        rstn = 1'b1;
        clear_counts();
        pix_idx = 0;
    endtask

    initial begin
        int n;
        bit seen;
        model_reset();
        clear_counts();
        pix_idx = 0;

        vecs[0] = '{en: 1'b0, pat: 2'd0, edges: 5,   de: 0,   fs: 0, hs: 0,  vs: 0};
        vecs[1] = '{en: 1'b1, pat: 2'd0, edges: 317, de: 120, fs: 3, hs: 21, vs: 45};
        vecs[2] = '{en: 1'b1, pat: 2'd3, edges: 105, de: 40,  fs: 1, hs: 7,  vs: 15};
        vecs[3] = '{en: 1'b1, pat: 2'd1, edges: 210, de: 80,  fs: 2, hs: 14, vs: 30};
        vecs[4] = '{en: 1'b1, pat: 2'd2, edges: 105, de: 40,  fs: 1, hs: 7,  vs: 15};
        vecs[5] = '{en: 1'b0, pat: 2'd0, edges: 130, de: 40,  fs: 1, hs: 7,  vs: 15};
        vecs[6] = '{en: 1'b0, pat: 2'd1, edges: 20,  de: 0,   fs: 0, hs: 0,  vs: 0};

        // Reset state
        do_reset();
        check("reset_outputs", dut_vec(), 34'd0);

        // Phase table: frame-aligned windows with known pulse counts
        for (int i = 0; i < 7; i++) begin
            i_en = vecs[i].en;
            i_pattern = vecs[i].pat;
            clear_counts();
            repeat (vecs[i].edges) step();
            check($sformatf("ph%0d_de", i), 34'(cnt_de), 34'(vecs[i].de));
            check($sformatf("ph%0d_fs", i), 34'(cnt_fs), 34'(vecs[i].fs));
            check($sformatf("ph%0d_hs", i), 34'(cnt_hs), 34'(vecs[i].hs));
            check($sformatf("ph%0d_vs", i), 34'(cnt_vs), 34'(vecs[i].vs));
        end

        // Enable dropped mid-frame, then re-asserted
        do_reset();
        i_en = 1'b1;
        run_until_fs(10);
        clear_counts();
        repeat (50) step();
        i_en = 1'b0;
        repeat (150) step();
        check("drop_de_total", 34'(cnt_de), 34'd40);
        check("drop_no_new_frame", 34'(cnt_fs), 34'd0);
        check("drop_idle_zero", dut_vec(), 34'd0);
        i_en = 1'b1;
        step();
        check("resume_e0", dut_vec(), 34'd0);
        step();
        check("resume_e1", dut_vec(), 34'd0);
        step();
        check("resume_e2_syncs", 34'({o_vsync, o_hsync, o_frame_start}), 34'd7);

        // Pattern switched mid-frame: takes effect next frame
        do_reset();
        i_en = 1'b1;
        run_until_fs(10);
        repeat (40) step();
        i_pattern = 2'd2;
        repeat (60) step();
        check("ramp_x5", 34'(pix_r[5]), 34'd5);
        check("ramp_line1_x3", 34'(pix_r[13]), 34'd3);
        run_until_fs(20);
        repeat (100) step();
        check("chk_0_0", 34'(pix_r[0]), 34'h000);
        check("chk_1_0", 34'(pix_r[1]), 34'h3FF);
        check("chk_0_1", 34'(pix_g[10]), 34'h3FF);
        check("chk_1_1", 34'(pix_b[11]), 34'h000);

        // ID pattern: blue carries the frame number
        do_reset();
        i_pattern = 2'd3;
        i_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_until_fs(120);
            repeat (100) step();
            check($sformatf("id_b_f%0d", k), 34'(pix_b[0]), 34'(k));
            check($sformatf("id_r_last_f%0d", k), 34'(pix_r[39]), 34'd9);
            check($sformatf("id_g_last_f%0d", k), 34'(pix_g[39]), 34'd3);
        end

        // Asynchronous reset mid-line, then restart from the frame origin
        repeat (25) step();
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", dut_vec(), 34'd0);
        model_reset();
        repeat (2) step();
        rstn = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            step();
            n++;
            seen = o_frame_start;
        end
        check("restart_latency", 34'(n), 34'd3);
        check("restart_syncs", 34'({o_vsync, o_hsync}), 34'd3);

        // Randomised enable/pattern activity against the model
        do_reset();
        i_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) i_en = ~i_en;
            if ($urandom_range(0, 9) == 0) i_pattern = 2'($urandom_range(0, 3));
            if (i == 1500) begin
                rstn = 1'b0;
                model_reset();
                step();
                rstn = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
